// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves RV32 conditional branches from precomputed comparator flags.
//   Accepts one request per cycle (valid/ready). Results appear one cycle after
//   acceptance. A taken, aligned branch raises redirect and then holds flush
//   high for FLUSH_CYCLES cycles. New requests are blocked during that time.
//
// Parameters
//   DATA_WIDTH   : PC / immediate width (default 32)
//   FLUSH_CYCLES : flush pulse length, 1..15 (default 2)
//
// Ports
//   clk, rst_n                  : clock, synchronous active-low reset
//   in_valid / in_ready         : request handshake
//   is_branch, funct3           : request kind and RV32 branch funct3
//   greater, equal, less, ltu   : signed / unsigned rs1-vs-rs2 comparator flags
//   pc, imm                     : branch PC and sign-extended B-immediate
//   out_valid                   : one-cycle result strobe per accepted request
//   taken, target_pc            : resolved condition and pc+imm (wraps)
//   redirect                    : taken && aligned, qualified by out_valid
//   misaligned, illegal         : error flags, qualified by out_valid
//   flush                       : squash younger stages
//
// Optional build macro BRANCH_STATS_EN adds two wrapping 32-bit counters:
//   resolved_count (out_valid pulses) and taken_count (redirects).
module branch_resolve_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_branch,
  input  logic [2:0]            funct3,
  input  logic                  greater,
  input  logic                  equal,
  input  logic                  less,
  input  logic                  ltu,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  out_valid,
  output logic                  taken,
  output logic [DATA_WIDTH-1:0] target_pc,
  output logic                  redirect,
  output logic                  misaligned,
  output logic                  illegal,
  output logic                  flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           resolved_count,
  output logic [31:0]           taken_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    FLUSH
  } state_t;

  state_t                state;
  logic [3:0]            cnt;

  logic                  accept;
  logic                  cond_taken;
  logic                  bad_funct3;
  logic [DATA_WIDTH-1:0] next_target;
  logic                  next_mis;

  // Branch condition decode; non-branches and reserved encodings never take.
  always_comb begin
    cond_taken = 1'b0;
    bad_funct3 = is_branch && (funct3 == 3'b010 || funct3 == 3'b011);
    if (is_branch) begin
      case (funct3)
        3'b000:  cond_taken = equal;
        3'b001:  cond_taken = ~equal;
        3'b100:  cond_taken = less;
        3'b101:  cond_taken = greater | equal;
        3'b110:  cond_taken = ltu;
        3'b111:  cond_taken = ~ltu;
        default: cond_taken = 1'b0;
      endcase
    end
    next_target = pc + imm;
    next_mis    = cond_taken && (next_target[1:0] != 2'b00);
  end

  // While a result with redirect is on the outputs, the next cycle enters
  // FLUSH, so nothing may be accepted.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      RESP:    in_ready = ~redirect;
      FLUSH:   in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      taken      <= 1'b0;
      target_pc  <= '0;
      redirect   <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      flush      <= 1'b0;
`ifdef BRANCH_STATS_EN
      resolved_count <= '0;
      taken_count    <= '0;
`endif
    end else begin
      // Result flags live for one cycle unless reloaded by a new acceptance.
      out_valid  <= 1'b0;
      taken      <= 1'b0;
      redirect   <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) state <= RESP;
        end
        RESP: begin
          if (redirect) begin
            state <= FLUSH;
            cnt   <= 4'(FLUSH_CYCLES);
            flush <= 1'b1;
          end else if (!accept) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (cnt == 4'd1) begin
            state <= IDLE;
            cnt   <= '0;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          flush <= 1'b0;
        end
      endcase

      if (accept) begin
        out_valid  <= 1'b1;
        taken      <= cond_taken;
        target_pc  <= next_target;
        misaligned <= next_mis;
        illegal    <= bad_funct3;
        redirect   <= cond_taken && !next_mis;
      end

`ifdef BRANCH_STATS_EN
      if (out_valid) resolved_count <= resolved_count + 32'd1;
      if (redirect)  taken_count    <= taken_count + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        is_branch;
  logic [2:0]  funct3;
  logic        greater, equal, less, ltu;
  logic [31:0] pc, imm;
  logic        out_valid, taken, redirect, misaligned, illegal, flush;
  logic [31:0] target_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] resolved_count, taken_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_WIDTH(32), .FLUSH_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_branch  (is_branch),
    .funct3     (funct3),
    .greater    (greater),
    .equal      (equal),
    .less       (less),
    .ltu        (ltu),
    .pc         (pc),
    .imm        (imm),
    .out_valid  (out_valid),
    .taken      (taken),
    .target_pc  (target_pc),
    .redirect   (redirect),
    .misaligned (misaligned),
    .illegal    (illegal),
    .flush      (flush)
`ifdef BRANCH_STATS_EN
    ,
    .resolved_count (resolved_count),
    .taken_count    (taken_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic isb, input logic [2:0] f3, input logic [31:0] p,
                     input logic [31:0] i, input logic g, input logic e,
                     input logic l, input logic u);
    in_valid  = 1'b1;
    is_branch = isb;
    funct3    = f3;
    pc        = p;
    imm       = i;
    greater   = g;
    equal     = e;
    less      = l;
    ltu       = u;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    greater  = 1'b0;
    equal    = 1'b0;
    less     = 1'b0;
    ltu      = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic t,
                         input logic [31:0] tgt, input logic rd,
                         input logic mis, input logic ill);
    check_eq({tag, ".out_valid"},  64'(out_valid),  64'(v));
    check_eq({tag, ".taken"},      64'(taken),      64'(t));
    check_eq({tag, ".target_pc"},  64'(target_pc),  64'(tgt));
    check_eq({tag, ".redirect"},   64'(redirect),   64'(rd));
    check_eq({tag, ".misaligned"}, 64'(misaligned), 64'(mis));
    check_eq({tag, ".illegal"},    64'(illegal),    64'(ill));
  endtask

  initial begin
    rst_n = 1'b0;
    is_branch = 1'b0;
    funct3 = 3'b000;
    pc = '0;
    imm = '0;
    idle_in();

    // Reset state
    step();
    step();
    chk_out("rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("rst.flush", 64'(flush), 64'd0);
    rst_n = 1'b1;
    step();
    check_eq("rst.in_ready", 64'(in_ready), 64'd1);

    // BEQ taken -> redirect, flush for 2 cycles, in_ready low for 3
    req(1'b1, 3'b000, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("beq.ready_pre", 64'(in_ready), 64'd1);
    step();
    idle_in();
    chk_out("beq", 1'b1, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
    check_eq("beq.flush0", 64'(flush), 64'd0);
    check_eq("beq.ready0", 64'(in_ready), 64'd0);
    // Request presented during flush must be ignored, then held upstream
    req(1'b1, 3'b000, 32'h400, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("beq.flush1", 64'(flush), 64'd1);
    check_eq("beq.ready1", 64'(in_ready), 64'd0);
    check_eq("beq.ov1", 64'(out_valid), 64'd0);
    check_eq("beq.rd1", 64'(redirect), 64'd0);
    step();
    check_eq("beq.flush2", 64'(flush), 64'd1);
    check_eq("beq.ready2", 64'(in_ready), 64'd0);
    check_eq("beq.ov2", 64'(out_valid), 64'd0);
    step();
    check_eq("beq.flush3", 64'(flush), 64'd0);
    check_eq("beq.ready3", 64'(in_ready), 64'd1);
    check_eq("beq.ov3", 64'(out_valid), 64'd0);
    step();
    idle_in();
    chk_out("held", 1'b1, 1'b0, 32'h410, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("held.ov_off", 64'(out_valid), 64'd0);
    check_eq("held.flush", 64'(flush), 64'd0);

    // BLTU not taken then BNE taken, back to back
    req(1'b1, 3'b110, 32'h200, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("bltu", 1'b1, 1'b0, 32'h208, 1'b0, 1'b0, 1'b0);
    check_eq("bltu.ready", 64'(in_ready), 64'd1);
    req(1'b1, 3'b001, 32'h300, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
    chk_out("bne", 1'b1, 1'b1, 32'h340, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("bne.flush1", 64'(flush), 64'd1);
    step();
    check_eq("bne.flush2", 64'(flush), 64'd1);
    step();
    check_eq("bne.flush3", 64'(flush), 64'd0);

    // BGE with wrapping, misaligned target
    req(1'b1, 3'b101, 32'hFFFF_FFF0, 32'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
    chk_out("bge", 1'b1, 1'b1, 32'h2, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("bge.flush", 64'(flush), 64'd0);
    check_eq("bge.mis_off", 64'(misaligned), 64'd0);
    check_eq("bge.ready", 64'(in_ready), 64'd1);

    // Back-to-back decode table: illegal, non-branch, BLT, BGEU
    req(1'b1, 3'b010, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk_out("ill010", 1'b1, 1'b0, 32'h4, 1'b0, 1'b0, 1'b1);
    req(1'b1, 3'b011, 32'h0, 32'h8, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk_out("ill011", 1'b1, 1'b0, 32'h8, 1'b0, 1'b0, 1'b1);
    req(1'b0, 3'b000, 32'h10, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("nobr", 1'b1, 1'b0, 32'h18, 1'b0, 1'b0, 1'b0);
    req(1'b1, 3'b111, 32'h20, 32'h8, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk_out("bgeu", 1'b1, 1'b0, 32'h28, 1'b0, 1'b0, 1'b0);
    req(1'b1, 3'b100, 32'h1000, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    idle_in();
    chk_out("blt", 1'b1, 1'b1, 32'hFFC, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("blt.flush1", 64'(flush), 64'd1);

    // Reset in the first flush cycle aborts the flush
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("rstfl.flush", 64'(flush), 64'd0);
    check_eq("rstfl.ov", 64'(out_valid), 64'd0);
    step();
    check_eq("rstfl.ready", 64'(in_ready), 64'd1);
    check_eq("rstfl.flush2", 64'(flush), 64'd0);

`ifdef BRANCH_STATS_EN
    check_eq("stats.res0", 64'(resolved_count), 64'd0);
    check_eq("stats.tk0", 64'(taken_count), 64'd0);
    force dut.taken_count = 32'hFFFF_FFFF;
    #1;
    release dut.taken_count;
    req(1'b1, 3'b000, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    idle_in();
    check_eq("stats.rd", 64'(redirect), 64'd1);
    step();
    check_eq("stats.tk_wrap", 64'(taken_count), 64'd0);
    check_eq("stats.res1", 64'(resolved_count), 64'd1);
    step();
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
